mux_sync_sel_nxm: RTL and testbench

Parametrised, registered N_IN-to-N_OUT 1-bit selector for routing PWM/carrier-compare signals to gate outputs. Each output channel has a shadow select written over a simple write port and an active select. The active select is committed only on a carrier-synchronous update strobe. On every select change, the channel is forced to a safe level for a programmable blanking time, so no glitch or shoot-through can reach the gate drivers. It sits between the PWM comparator bank and the output/dead-time stage, and supersedes the fixed 8x1 combinational mux.

---
 rtl/mux_sync_sel_nxm_pkg.sv | 18 +
 rtl/mux_sync_sel_nxm_chan.sv | 91 +++++++++
 rtl/mux_sync_sel_nxm.sv | 52 +++++
 tb/tb_mux_sync_sel_nxm.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_sync_sel_nxm_pkg.sv
// Shared types and helpers for the synchronised N_IN x N_OUT gate-signal selector.
package mux_sync_sel_nxm_pkg;

  localparam logic SAFE_LVL_DEF = 1'b0;

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } chan_state_t;

  // Width needed to hold v-1 (i.e. $clog2(v)), never less than one bit.
  function automatic int clog2_min1(input int v);
    int w;
    w = $clog2(v);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_sync_sel_nxm_chan.sv
// One output channel: shadow/active select, RUN/BLANK FSM, blank counter and output register.
module mux_sync_sel_chan
  import mux_sync_sel_nxm_pkg::*;
#(
  parameter int   N_IN      = 8,
  parameter int   SEL_W     = $clog2(N_IN),
  parameter int   BLANK_CYC = 4,
  parameter logic SAFE_LVL  = SAFE_LVL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_data,
  input  logic             commit,
  output logic             out,
  output logic             blank,
  output logic             pend
);

  localparam int  CNT_W    = clog2_min1(BLANK_CYC + 1);
  localparam bit  BLANK_EN = (BLANK_CYC > 0);

  logic [SEL_W-1:0] r_shadow;
  logic [SEL_W-1:0] r_active;
  logic [CNT_W-1:0] r_cnt;
  chan_state_t      r_state;
  logic             r_out;
  logic             r_pend;

  logic [SEL_W-1:0] w_wr_val;
  logic [SEL_W-1:0] w_shadow_nxt;
  logic [SEL_W-1:0] w_active_nxt;
  logic             w_change;
  chan_state_t      w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_out_nxt;

  // Out-of-range selects (non-power-of-2 N_IN) collapse to input 0.
  assign w_wr_val     = ({{(32-SEL_W){1'b0}}, wr_data} < 32'(N_IN)) ? wr_data : '0;
  assign w_change     = commit && (r_shadow != r_active);
  assign w_active_nxt = w_change ? r_shadow : r_active;
  assign w_shadow_nxt = wr_en ? w_wr_val : r_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_pend   <= 1'b0;
      r_out    <= SAFE_LVL;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_active <= w_active_nxt;
      r_pend   <= (w_shadow_nxt != w_active_nxt);
      r_out    <= w_out_nxt;
    end
  end

  // A changing commit (re)loads the full blank even mid-blank; the count-1 cycle releases to RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_change && BLANK_EN) begin
      w_state_nxt = BLANK;
      w_cnt_nxt   = CNT_W'(BLANK_CYC);
    end else if (r_state == BLANK) begin
      if (r_cnt <= CNT_W'(1)) begin
        w_state_nxt = RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_out_nxt = in_vec[r_active];
    if (w_state_nxt == BLANK) begin
      w_out_nxt = SAFE_LVL;
    end
  end

  assign out   = r_out;
  assign blank = (r_state == BLANK);
  assign pend  = r_pend;

endmodule

// File: rtl/mux_sync_sel_nxm.sv
// Registered N_IN-to-N_OUT selector with carrier-synchronous select commit and
// per-channel blanking to a safe level on every select change.
module mux_sync_sel_nxm
  import mux_sync_sel_nxm_pkg::*;
#(
  parameter int   N_IN      = 8,
  parameter int   N_OUT     = 4,
  parameter int   SEL_W     = $clog2(N_IN),
  parameter int   CH_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  parameter int   BLANK_CYC = 4,
  parameter logic SAFE_LVL  = SAFE_LVL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             sel_wr_en,
  input  logic [CH_W-1:0]  sel_wr_ch,
  input  logic [SEL_W-1:0] sel_wr_data,
  input  logic             upd_en,
  input  logic             upd_strobe,
  output logic [N_OUT-1:0] out_vec,
  output logic [N_OUT-1:0] blank_vec,
  output logic [N_OUT-1:0] sel_pend
);

  logic w_commit;
  assign w_commit = upd_en && upd_strobe;

  // Channel indices >= N_OUT match no instance, so such writes are dropped.
  for (genvar k = 0; k < N_OUT; k++) begin : g_chan
    logic w_wr_en;
    assign w_wr_en = sel_wr_en && (sel_wr_ch == CH_W'(k));

    mux_sync_sel_chan #(
      .N_IN      (N_IN),
      .SEL_W     (SEL_W),
      .BLANK_CYC (BLANK_CYC),
      .SAFE_LVL  (SAFE_LVL)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .in_vec  (in_vec),
      .wr_en   (w_wr_en),
      .wr_data (sel_wr_data),
      .commit  (w_commit),
      .out     (out_vec[k]),
      .blank   (blank_vec[k]),
      .pend    (sel_pend[k])
    );
  end

endmodule

// File: tb/tb_mux_sync_sel_nxm.sv
// Scoreboard bench: a default 8x4 instance with blanking, and a 6x3 instance without.
module tb_mux_sync_sel_nxm;

  typedef struct packed {
    logic [3:0] out;
    logic [3:0] blank;
    logic [3:0] pend;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_vec;
  logic       sel_wr_en;
  logic [1:0] sel_wr_ch;
  logic [2:0] sel_wr_data;
  logic       upd_en;
  logic       upd_strobe;

  logic [3:0] out0, blank0, pend0;
  logic [2:0] out1, blank1, pend1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int nin [2] = '{8, 6};
  int nout[2] = '{4, 3};
  int blk [2] = '{4, 0};
  int m_sh  [2][4];
  int m_act [2][4];
  int m_safe[2][4];

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  mux_sync_sel_nxm dut0 (
    .clk(clk), .rst(rst), .in_vec(in_vec), .sel_wr_en(sel_wr_en),
    .sel_wr_ch(sel_wr_ch), .sel_wr_data(sel_wr_data), .upd_en(upd_en),
    .upd_strobe(upd_strobe), .out_vec(out0), .blank_vec(blank0), .sel_pend(pend0)
  );

  mux_sync_sel_nxm #(.N_IN(6), .N_OUT(3), .BLANK_CYC(0)) dut1 (
    .clk(clk), .rst(rst), .in_vec(in_vec[5:0]), .sel_wr_en(sel_wr_en),
    .sel_wr_ch(sel_wr_ch), .sel_wr_data(sel_wr_data), .upd_en(upd_en),
    .upd_strobe(upd_strobe), .out_vec(out1), .blank_vec(blank1), .sel_pend(pend1)
  );

  // Reference: each channel keeps a count of safe output cycles still owed.
  function automatic exp_t model(int d);
    exp_t e;
    int   old_act;
    e = '0;
    for (int k = 0; k < nout[d]; k++) begin
      if (rst) begin
        m_sh[d][k] = 0; m_act[d][k] = 0; m_safe[d][k] = 0;
      end else begin
        old_act = m_act[d][k];
        if (upd_en && upd_strobe && (m_sh[d][k] != m_act[d][k])) begin
          m_act[d][k] = m_sh[d][k];
          if (blk[d] > 0) m_safe[d][k] = blk[d];
        end
        if (m_safe[d][k] > 0) begin
          e.blank[k] = 1'b1;
          m_safe[d][k]--;
        end else begin
          e.out[k] = in_vec[old_act];
        end
      end
    end
    if (!rst && sel_wr_en && (int'(sel_wr_ch) < nout[d]))
      m_sh[d][sel_wr_ch] = (int'(sel_wr_data) < nin[d]) ? int'(sel_wr_data) : 0;
    for (int k = 0; k < nout[d]; k++)
      e.pend[k] = (m_sh[d][k] != m_act[d][k]);
    return e;
  endfunction

  task automatic step(input logic r, input logic [7:0] iv, input logic we,
                      input logic [1:0] ch, input logic [2:0] wd,
                      input logic en, input logic stb);
    rst = r; in_vec = iv; sel_wr_en = we; sel_wr_ch = ch; sel_wr_data = wd;
    upd_en = en; upd_strobe = stb;
    q0.push_back(model(0));
    q1.push_back(model(1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [7:0] iv);
    for (int i = 0; i < n; i++) step(1'b0, iv, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input int d, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h exp=%h", nm, d, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("out_vec",   0, out0,   e.out);
      chk("blank_vec", 0, blank0, e.blank);
      chk("sel_pend",  0, pend0,  e.pend);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("out_vec",   1, {1'b0, out1},   e.out);
      chk("blank_vec", 1, {1'b0, blank1}, e.blank);
      chk("sel_pend",  1, {1'b0, pend1},  e.pend);
    end
  end

  initial begin
    logic [7:0] iv;
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA5, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    idle(2, 8'hA5);
    // ch2 -> input 3, pending until the strobe
    step(1'b0, 8'hA5, 1'b1, 2'd2, 3'd3, 1'b0, 1'b0);
    idle(2, 8'hA5);
    step(1'b0, 8'hA5, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    iv = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      iv[3] = ~iv[3];
      idle(1, iv);
    end
    // write and strobe together: commit uses the old shadow
    step(1'b0, 8'hA5, 1'b1, 2'd1, 3'd5, 1'b1, 1'b1);
    idle(3, 8'hA5);
    step(1'b0, 8'hA5, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    idle(6, 8'hFF);
    // reload mid-blank
    step(1'b0, 8'hFF, 1'b1, 2'd0, 3'd2, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    step(1'b0, 8'hFF, 1'b1, 2'd0, 3'd4, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    idle(8, 8'hFF);
    // strobe with upd_en=0 has no effect
    step(1'b0, 8'hFF, 1'b1, 2'd3, 3'd6, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
    idle(3, 8'hFF);
    // ch3 is out of range for the 3-channel instance; data 7 >= 6 stores 0 there
    step(1'b0, 8'hFF, 1'b1, 2'd3, 3'd1, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 1'b1, 2'd0, 3'd7, 1'b0, 1'b0);
    step(1'b0, 8'hFF, 1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    idle(2, 8'hFF);
    step(1'b1, 8'hFF, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    idle(3, 8'hFF);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), 8'($urandom), ($urandom_range(0, 2) == 0),
           2'($urandom), 3'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0));
    end
    idle(2, 8'h00);
    @(negedge clk);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain q0=%0d q1=%0d exp=0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
